// File: rtl/rptr_handler_fwft.sv
// rptr_handler_fwft
//   Read-side pointer handler for the async FIFO, clocked by rclk.
//   Keeps the binary/Gray read pointers and detects empty against the
//   synchronised Gray write pointer. It drives the memory read port and
//   presents the head word first-word-fall-through from the memory's
//   registered output. It also reports fill level, almost-empty and a
//   sticky underflow flag.
//
// Ports
//   rclk, rrst_n   read clock, asynchronous active-low reset
//   r_en           consumer pop (honoured only while rd_valid)
//   g_wptr_sync    Gray write pointer, already synchronised into rclk
//   b_rptr/g_rptr  binary / Gray read pointers (registered)
//   mem_raddr      memory read address
//   mem_re         memory read enable (memory registers its output on it)
//   mem_rdata      registered memory output
//   rd_data        FWFT head word, meaningful while rd_valid
//   rd_valid       head word present; empty is its inverse
//   fill_level     words available to the reader (registered, one cycle late)
//   almost_empty   fill_level <= AE_LEVEL (registered with fill_level)
//   underflow      sticky, set by r_en while no head word is present
module rptr_handler_fwft #(
    parameter int PTR_WIDTH  = 3,
    parameter int DATA_WIDTH = 8,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  r_en,
    input  logic [PTR_WIDTH:0]    g_wptr_sync,
    output logic [PTR_WIDTH:0]    b_rptr,
    output logic [PTR_WIDTH:0]    g_rptr,
    output logic [PTR_WIDTH-1:0]  mem_raddr,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic [PTR_WIDTH+1:0]  fill_level,
    output logic                  almost_empty,
    output logic                  underflow
);

    localparam logic [PTR_WIDTH+1:0] AE_THRESH = AE_LEVEL[PTR_WIDTH+1:0];

    logic                 ptr_empty;
    logic                 pop;
    logic [PTR_WIDTH:0]   b_next;
    logic [PTR_WIDTH:0]   b_wptr;
    logic [PTR_WIDTH:0]   diff;
    logic [PTR_WIDTH+1:0] fill_next;
    logic                 ae_next;

    // ptr_empty means nothing is left in memory beyond the head word.
    assign ptr_empty = (g_rptr == g_wptr_sync);
    assign pop       = r_en & rd_valid;
    // Refill the output stage when it is empty or being drained this cycle.
    assign mem_re    = !ptr_empty & (!rd_valid | pop);
    assign b_next    = b_rptr + {{PTR_WIDTH{1'b0}}, 1'b1};
    assign mem_raddr = b_rptr[PTR_WIDTH-1:0];
    assign rd_data   = mem_rdata;
    assign empty     = !rd_valid;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        b_wptr = '0;
        for (int unsigned i = 0; i <= PTR_WIDTH; i++) begin
            b_wptr[i] = ^(g_wptr_sync >> i);
        end
    end

    // The head word has already left memory, so it is added on top of the
    // pointer difference; the range therefore reaches 2**PTR_WIDTH + 1.
    always_comb begin
        diff      = b_wptr - b_rptr;
        fill_next = {1'b0, diff} + {{(PTR_WIDTH+1){1'b0}}, rd_valid};
        ae_next   = (fill_next <= AE_THRESH);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            b_rptr       <= '0;
            g_rptr       <= '0;
            rd_valid     <= 1'b0;
            fill_level   <= '0;
            almost_empty <= 1'b1;
            underflow    <= 1'b0;
        end else begin
            if (mem_re) begin
                b_rptr <= b_next;
                g_rptr <= (b_next >> 1) ^ b_next;
            end

            if (mem_re) begin
                rd_valid <= 1'b1;
            end else if (pop) begin
                rd_valid <= 1'b0;
            end

            fill_level   <= fill_next;
            almost_empty <= ae_next;

            if (r_en && !rd_valid) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rptr_handler_fwft.sv
// Testbench for rptr_handler_fwft: a small memory and a writer that drives
// g_wptr_sync directly, plus a queue-based model of the reader's view.
module tb_rptr_handler_fwft;

    localparam int PW = 3;
    localparam int DW = 8;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          rrst_n;
    logic          r_en;
    logic [PW:0]   g_wptr_sync;
    logic [PW:0]   b_rptr;
    logic [PW:0]   g_rptr;
    logic [PW-1:0] mem_raddr;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic [PW+1:0] fill_level;
    logic          almost_empty;
    logic          underflow;

    rptr_handler_fwft #(
        .PTR_WIDTH  (PW),
        .DATA_WIDTH (DW),
        .AE_LEVEL   (AE)
    ) dut (
        .rclk         (clk),
        .rrst_n       (rrst_n),
        .r_en         (r_en),
        .g_wptr_sync  (g_wptr_sync),
        .b_rptr       (b_rptr),
        .g_rptr       (g_rptr),
        .mem_raddr    (mem_raddr),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .fill_level   (fill_level),
        .almost_empty (almost_empty),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // FIFO storage with a registered read port.
    logic [DW-1:0] mem [2**PW];
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_raddr];
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: words written but not yet fetched, plus the head word.
    logic [PW:0]   w;
    logic [PW:0]   rp;
    logic [DW-1:0] mq [$];
    logic          head_v;
    logic [DW-1:0] head_d;
    logic          uf_e;
    logic [PW+1:0] fill_e;
    logic          ae_e;

    typedef struct {
        bit         wr;
        logic [7:0] d;
        bit         re;
        bit         exp_re;
        bit         exp_v;
        logic [3:0] exp_b;
        logic [4:0] exp_fill;
        bit         exp_ae;
        bit         exp_uf;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [PW:0] gray(input logic [PW:0] x);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        w           = '0;
        g_wptr_sync = '0;
        rp          = '0;
        mq.delete();
        head_v      = 1'b0;
        head_d      = '0;
        uf_e        = 1'b0;
        fill_e      = '0;
        ae_e        = 1'b1;
    endtask

    task automatic do_reset();
        rrst_n = 1'b0;
        r_en   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rrst_n = 1'b1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        if (mq.size() < 2**PW) begin
            mem[w[PW-1:0]] = d;
            mq.push_back(d);
            w           = w + 1'b1;
            g_wptr_sync = gray(w);
        end
    endtask

    task automatic check_state();
        chk("rd_valid",     32'(rd_valid),     32'(head_v));
        chk("empty",        32'(empty),        32'(!head_v));
        chk("b_rptr",       32'(b_rptr),       32'(rp));
        chk("g_rptr",       32'(g_rptr),       32'(gray(rp)));
        chk("fill_level",   32'(fill_level),   32'(fill_e));
        chk("almost_empty", 32'(almost_empty), 32'(ae_e));
        chk("underflow",    32'(underflow),    32'(uf_e));
        if (head_v) chk("rd_data", 32'(rd_data), 32'(head_d));
    endtask

    // Called at a falling edge (after any writes); runs one rclk cycle.
    task automatic cycle(input logic re, output logic seen_re);
        logic pop;
        logic exp_re;
        r_en = re;
        #1;
        pop    = re && head_v;
        exp_re = (mq.size() > 0) && (!head_v || pop);
        seen_re = mem_re;
        chk("mem_re", 32'(mem_re), 32'(exp_re));
        if (exp_re) chk("mem_raddr", 32'(mem_raddr), 32'(rp[PW-1:0]));
        @(posedge clk);
        fill_e = 5'(mq.size()) + 5'(head_v);
        ae_e   = (fill_e <= 5'(AE));
        if (re && !head_v) uf_e = 1'b1;
        if (exp_re) begin
            head_d = mq.pop_front();
            head_v = 1'b1;
            rp     = rp + 1'b1;
        end else if (pop) begin
            head_v = 1'b0;
        end
        @(negedge clk);
        check_state();
    endtask

    logic s_re;

    initial begin
        tbl[0] = '{0, 8'h00, 0, 0, 0, 4'd0, 5'd0, 1, 0, 8'h00};
        tbl[1] = '{1, 8'h11, 0, 1, 1, 4'd1, 5'd1, 1, 0, 8'h11};
        tbl[2] = '{0, 8'h00, 0, 0, 1, 4'd1, 5'd1, 1, 0, 8'h11};
        tbl[3] = '{0, 8'h00, 1, 0, 0, 4'd1, 5'd1, 1, 0, 8'h00};
        tbl[4] = '{0, 8'h00, 0, 0, 0, 4'd1, 5'd0, 1, 0, 8'h00};
        tbl[5] = '{0, 8'h00, 1, 0, 0, 4'd1, 5'd0, 1, 1, 8'h00};
        tbl[6] = '{1, 8'h22, 0, 1, 1, 4'd2, 5'd1, 1, 1, 8'h22};
        tbl[7] = '{1, 8'h33, 1, 1, 1, 4'd3, 5'd2, 0, 1, 8'h33};
        tbl[8] = '{0, 8'h00, 1, 0, 0, 4'd3, 5'd1, 1, 1, 8'h00};
        tbl[9] = '{0, 8'h00, 0, 0, 0, 4'd3, 5'd0, 1, 1, 8'h00};

        // Reset values
        do_reset();
        @(negedge clk);
        chk("rst_empty",        32'(empty),        32'd1);
        chk("rst_rd_valid",     32'(rd_valid),     32'd0);
        chk("rst_mem_re",       32'(mem_re),       32'd0);
        chk("rst_fill",         32'(fill_level),   32'd0);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_underflow",    32'(underflow),    32'd0);

        // Directed vector table: first-word latency, pop, underflow, refill
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].wr) write_word(tbl[i].d);
            cycle(tbl[i].re, s_re);
            chk($sformatf("tbl%0d_mem_re", i),   32'(s_re),         32'(tbl[i].exp_re));
            chk($sformatf("tbl%0d_rd_valid", i), 32'(rd_valid),     32'(tbl[i].exp_v));
            chk($sformatf("tbl%0d_b_rptr", i),   32'(b_rptr),       32'(tbl[i].exp_b));
            chk($sformatf("tbl%0d_fill", i),     32'(fill_level),   32'(tbl[i].exp_fill));
            chk($sformatf("tbl%0d_ae", i),       32'(almost_empty), 32'(tbl[i].exp_ae));
            chk($sformatf("tbl%0d_uf", i),       32'(underflow),    32'(tbl[i].exp_uf));
            if (tbl[i].exp_v) chk($sformatf("tbl%0d_data", i), 32'(rd_data), 32'(tbl[i].exp_data));
        end

        // Full FIFO streamed out back-to-back
        do_reset();
        for (int i = 0; i < 8; i++) write_word(8'(8'h40 + i));
        chk("full_gwptr", 32'(g_wptr_sync), 32'b1100);
        cycle(1'b0, s_re);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("stream_valid%0d", i), 32'(rd_valid), 32'd1);
            chk($sformatf("stream_data%0d", i),  32'(rd_data),  32'(8'h40 + i));
            cycle(1'b1, s_re);
        end
        chk("stream_end_valid", 32'(rd_valid),  32'd0);
        chk("stream_end_b",     32'(b_rptr),    32'd8);
        chk("stream_end_g",     32'(g_rptr),    32'b1100);
        chk("stream_end_uf",    32'(underflow), 32'd0);

        // Advance to b_rptr=15, then read across the pointer wrap
        for (int i = 0; i < 7; i++) write_word(8'(8'h60 + i));
        cycle(1'b0, s_re);
        for (int i = 0; i < 7; i++) cycle(1'b1, s_re);
        chk("pre_wrap_b", 32'(b_rptr), 32'd15);
        chk("pre_wrap_g", 32'(g_rptr), 32'b1000);
        write_word(8'hA7);
        write_word(8'hB0);
        #1;
        chk("wrap_raddr7", 32'(mem_raddr), 32'd7);
        cycle(1'b0, s_re);
        chk("wrap_b0",     32'(b_rptr),   32'd0);
        chk("wrap_valid0", 32'(rd_valid), 32'd1);
        chk("wrap_data7",  32'(rd_data),  32'hA7);
        #1;
        chk("wrap_raddr0", 32'(mem_raddr), 32'd0);
        cycle(1'b1, s_re);
        chk("wrap_b1",     32'(b_rptr),   32'd1);
        chk("wrap_valid1", 32'(rd_valid), 32'd1);
        chk("wrap_data0",  32'(rd_data),  32'hB0);
        cycle(1'b1, s_re);
        chk("wrap_drained", 32'(rd_valid), 32'd0);

        // Underflow is sticky across later valid pops
        cycle(1'b1, s_re);
        chk("uf_set", 32'(underflow), 32'd1);
        chk("uf_b",   32'(b_rptr),    32'd1);
        write_word(8'hC1);
        cycle(1'b0, s_re);
        cycle(1'b1, s_re);
        chk("uf_sticky", 32'(underflow), 32'd1);

        // Asynchronous reset mid-stream with rd_valid=1, b_rptr=5
        do_reset();
        for (int i = 0; i < 7; i++) write_word(8'(8'h80 + i));
        cycle(1'b0, s_re);
        for (int i = 0; i < 4; i++) cycle(1'b1, s_re);
        chk("arst_pre_b",     32'(b_rptr),   32'd5);
        chk("arst_pre_valid", 32'(rd_valid), 32'd1);
        #2;
        rrst_n = 1'b0;
        r_en   = 1'b1;
        #1;
        chk("arst_b",       32'(b_rptr),       32'd0);
        chk("arst_g",       32'(g_rptr),       32'd0);
        chk("arst_valid",   32'(rd_valid),     32'd0);
        chk("arst_empty",   32'(empty),        32'd1);
        chk("arst_fill",    32'(fill_level),   32'd0);
        chk("arst_ae",      32'(almost_empty), 32'd1);
        chk("arst_uf",      32'(underflow),    32'd0);
        model_reset();
        @(negedge clk);
        chk("arst_ren_ignored", 32'(underflow), 32'd0);
        r_en   = 1'b0;
        rrst_n = 1'b1;
        @(negedge clk);
        check_state();

        // Randomised traffic against the model, with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            if ($urandom_range(0, 99) < 45) write_word(8'($urandom));
            cycle($urandom_range(0, 99) < 50, s_re);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
